// File: rtl/beehive_udp_arb_pkg.sv
// Types and helpers for the UDP transmit arbiter.
package beehive_udp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        META = 2'd1,
        DATA = 2'd2
    } udp_arb_state_e;

    localparam int unsigned UDP_LEN_W = 16;
    // One extra bit so the round-up add cannot wrap for len = 0xFFFF.
    localparam int unsigned BEATS_W   = UDP_LEN_W + 1;

    // Number of data beats needed for len payload bytes, beat size 2**bytes_log2.
    function automatic logic [BEATS_W-1:0] udp_len_to_beats(
        input logic [UDP_LEN_W-1:0] len,
        input int unsigned          bytes_log2
    );
        logic [BEATS_W-1:0] round_up;
        round_up = (BEATS_W'(1) << bytes_log2) - BEATS_W'(1);
        return ({1'b0, len} + round_up) >> bytes_log2;
    endfunction

endpackage

// File: rtl/beehive_udp_msg.sv
// UDP message descriptor shared by the app engines and the to_udp transmit port.
package beehive_udp_msg;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] data_length;
    } udp_info;

endpackage

// File: rtl/rr_arb_onehot.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module rr_arb_onehot #(
    parameter int unsigned NUM_SRCS  = 2,
    parameter int unsigned SRC_IDX_W = $clog2(NUM_SRCS)
) (
    input  logic [NUM_SRCS-1:0]  req,
    input  logic [SRC_IDX_W-1:0] rr_ptr,
    output logic [NUM_SRCS-1:0]  grant_oh,
    output logic [SRC_IDX_W-1:0] grant_idx,
    output logic                 grant_val
);

    int unsigned          cand;
    logic [SRC_IDX_W-1:0] cand_idx;

    // Scan from rr_ptr upward and keep the first requester found.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_val = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < NUM_SRCS; i++) begin
            cand     = (32'(rr_ptr) + i) % NUM_SRCS;
            cand_idx = cand[SRC_IDX_W-1:0];
            if (!grant_val && req[cand_idx]) begin
                grant_val          = 1'b1;
                grant_oh[cand_idx] = 1'b1;
                grant_idx          = cand_idx;
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Shares one to_udp transmit port between several app engines. Round-robin on meta
// requests; the winner keeps the port until every data beat of its packet has drained.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif

module udp_tx_arbiter
    import beehive_udp_msg::*;
    import beehive_udp_arb_pkg::*;
#(
    parameter int unsigned NUM_SRCS   = 2,
    parameter int unsigned NOC_DATA_W = `NOC_DATA_WIDTH,
    parameter int unsigned SRC_IDX_W  = $clog2(NUM_SRCS)
) (
    input  logic                           clk,
    input  logic                           rst_n,

    input  logic [NUM_SRCS-1:0]            src_arb_meta_val,
    input  udp_info                        src_arb_meta_info [NUM_SRCS],
    output logic [NUM_SRCS-1:0]            arb_src_meta_rdy,

    input  logic [NUM_SRCS-1:0]            src_arb_data_val,
    input  logic [NUM_SRCS*NOC_DATA_W-1:0] src_arb_data,
    output logic [NUM_SRCS-1:0]            arb_src_data_rdy,

    output logic                           arb_to_udp_meta_val,
    output udp_info                        arb_to_udp_meta_info,
    input  logic                           to_udp_arb_meta_rdy,

    output logic                           arb_to_udp_data_val,
    output logic [NOC_DATA_W-1:0]          arb_to_udp_data,
    input  logic                           to_udp_arb_data_rdy,

    output logic                           arb_busy,
    output logic [SRC_IDX_W-1:0]           arb_grant_idx
);

    localparam int unsigned NOC_DATA_BYTES = NOC_DATA_W / 8;
    localparam int unsigned BYTES_LOG2     = $clog2(NOC_DATA_BYTES);

    udp_arb_state_e       state_q, state_d;
    logic [SRC_IDX_W-1:0] grant_q, grant_d;
    logic [NUM_SRCS-1:0]  grant_oh_q, grant_oh_d;
    logic [SRC_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [BEATS_W-1:0]   beats_left_q, beats_left_d;
    logic [BEATS_W-1:0]   pkt_beats;

    logic [NUM_SRCS-1:0]  req_oh;
    logic [SRC_IDX_W-1:0] req_idx;
    logic                 req_val;

    rr_arb_onehot #(
        .NUM_SRCS  (NUM_SRCS),
        .SRC_IDX_W (SRC_IDX_W)
    ) u_rr_arb (
        .req       (src_arb_meta_val),
        .rr_ptr    (rr_ptr_q),
        .grant_oh  (req_oh),
        .grant_idx (req_idx),
        .grant_val (req_val)
    );

    // Payloads always follow the current grant; only the valids are gated by state.
    assign arb_to_udp_meta_info = src_arb_meta_info[grant_q];
    assign arb_to_udp_data      = src_arb_data[32'(grant_q) * NOC_DATA_W +: NOC_DATA_W];
    assign arb_busy             = (state_q != IDLE);
    assign arb_grant_idx        = grant_q;

    // Arbitration, packet tracking and handshake steering to/from the granted source.
    always_comb begin
        state_d             = state_q;
        grant_d             = grant_q;
        grant_oh_d          = grant_oh_q;
        rr_ptr_d            = rr_ptr_q;
        beats_left_d        = beats_left_q;
        arb_to_udp_meta_val = 1'b0;
        arb_src_meta_rdy    = '0;
        arb_to_udp_data_val = 1'b0;
        arb_src_data_rdy    = '0;
        pkt_beats           = udp_len_to_beats(arb_to_udp_meta_info.data_length, BYTES_LOG2);

        case (state_q)
            IDLE: begin
                if (req_val) begin
                    grant_d    = req_idx;
                    grant_oh_d = req_oh;
                    state_d    = META;
                end
            end
            META: begin
                arb_to_udp_meta_val = src_arb_meta_val[grant_q];
                arb_src_meta_rdy    = grant_oh_q & {NUM_SRCS{to_udp_arb_meta_rdy}};
                if (arb_to_udp_meta_val && to_udp_arb_meta_rdy) begin
                    // Next arbitration starts just past the winner so others go first.
                    rr_ptr_d = (grant_q == SRC_IDX_W'(NUM_SRCS - 1)) ? '0
                                                                      : grant_q + SRC_IDX_W'(1);
                    if (pkt_beats == '0) begin
                        state_d = IDLE;
                    end else begin
                        beats_left_d = pkt_beats;
                        state_d      = DATA;
                    end
                end
            end
            DATA: begin
                arb_to_udp_data_val = src_arb_data_val[grant_q];
                arb_src_data_rdy    = grant_oh_q & {NUM_SRCS{to_udp_arb_data_rdy}};
                if (arb_to_udp_data_val && to_udp_arb_data_rdy) begin
                    beats_left_d = beats_left_q - BEATS_W'(1);
                    if (beats_left_q == BEATS_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            grant_oh_q   <= NUM_SRCS'(1);
            rr_ptr_q     <= '0;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            grant_oh_q   <= grant_oh_d;
            rr_ptr_q     <= rr_ptr_d;
            beats_left_q <= beats_left_d;
        end
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: behavioural sources, per-scenario checks.
module tb_udp_tx_arbiter;
    import beehive_udp_msg::*;

    localparam int NS = 2;
    localparam int DW = 512;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NS-1:0]   src_arb_meta_val;
    udp_info         src_arb_meta_info [NS];
    logic [NS-1:0]   arb_src_meta_rdy;
    logic [NS-1:0]   src_arb_data_val;
    logic [NS*DW-1:0] src_arb_data;
    logic [NS-1:0]   arb_src_data_rdy;
    logic            arb_to_udp_meta_val;
    udp_info         arb_to_udp_meta_info;
    logic            to_udp_arb_meta_rdy;
    logic            arb_to_udp_data_val;
    logic [DW-1:0]   arb_to_udp_data;
    logic            to_udp_arb_data_rdy;
    logic            arb_busy;
    logic [0:0]      arb_grant_idx;

    udp_tx_arbiter #(
        .NUM_SRCS   (NS),
        .NOC_DATA_W (DW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .src_arb_meta_val     (src_arb_meta_val),
        .src_arb_meta_info    (src_arb_meta_info),
        .arb_src_meta_rdy     (arb_src_meta_rdy),
        .src_arb_data_val     (src_arb_data_val),
        .src_arb_data         (src_arb_data),
        .arb_src_data_rdy     (arb_src_data_rdy),
        .arb_to_udp_meta_val  (arb_to_udp_meta_val),
        .arb_to_udp_meta_info (arb_to_udp_meta_info),
        .to_udp_arb_meta_rdy  (to_udp_arb_meta_rdy),
        .arb_to_udp_data_val  (arb_to_udp_data_val),
        .arb_to_udp_data      (arb_to_udp_data),
        .to_udp_arb_data_rdy  (to_udp_arb_data_rdy),
        .arb_busy             (arb_busy),
        .arb_grant_idx        (arb_grant_idx)
    );

    always #5 clk = ~clk;

    // Source model state
    int pkts_left [NS];
    int pkt_len   [NS];
    bit in_data   [NS];
    bit early     [NS];
    int beats_rem [NS];
    int beat_no   [NS];
    int cur_pkt   [NS];
    bit toggle_rdy;

    // Observation logs
    int          meta_src_q  [$];
    logic [15:0] meta_port_q [$];
    int          data_src_q  [$];
    logic [31:0] data_word_q [$];
    int          rdy_viol;
    int          hold_viol;
    logic        prev_stall;
    logic [DW-1:0] prev_data;

    int errors;
    int checks;
    int n;

    function automatic logic [31:0] tag(input int s, input int p, input int b);
        return {8'(s), 8'(p), 16'(b)};
    endfunction

    task automatic drive_inputs();
        for (int s = 0; s < NS; s++) begin
            src_arb_meta_val[s]              = (pkts_left[s] > 0) && !in_data[s];
            src_arb_meta_info[s]             = '0;
            src_arb_meta_info[s].src_port    = 16'(16'h100 + s);
            src_arb_meta_info[s].data_length = 16'(pkt_len[s]);
            src_arb_data_val[s]              = in_data[s] || (early[s] && src_arb_meta_val[s]);
            src_arb_data[s*DW +: DW]         = {{(DW-32){1'b0}}, tag(s, cur_pkt[s], beat_no[s])};
        end
    endtask

    task automatic start_src(input int s, input int npkts, input int len, input bit e);
        pkts_left[s] = npkts;
        pkt_len[s]   = len;
        early[s]     = e;
        in_data[s]   = 1'b0;
        beats_rem[s] = 0;
        beat_no[s]   = 0;
        cur_pkt[s]   = 0;
        drive_inputs();
    endtask

    task automatic clear_logs();
        meta_src_q.delete();
        meta_port_q.delete();
        data_src_q.delete();
        data_word_q.delete();
    endtask

    // One clock: observe at negedge, update sources just after posedge, settle.
    task automatic tick();
        logic [NS-1:0] mh;
        logic [NS-1:0] dh;
        @(negedge clk);
        mh = src_arb_meta_val & arb_src_meta_rdy;
        dh = src_arb_data_val & arb_src_data_rdy;
        for (int s = 0; s < NS; s++) begin
            if (arb_src_data_rdy[s] && !in_data[s]) rdy_viol++;
            if (arb_src_meta_rdy[s] && (arb_grant_idx != 1'(s))) rdy_viol++;
            if (mh[s]) meta_src_q.push_back(s);
            if (dh[s]) data_src_q.push_back(s);
        end
        if ((arb_to_udp_meta_val && to_udp_arb_meta_rdy) != (|mh)) rdy_viol++;
        if ((arb_to_udp_data_val && to_udp_arb_data_rdy) != (|dh)) rdy_viol++;
        if (arb_to_udp_meta_val && to_udp_arb_meta_rdy)
            meta_port_q.push_back(arb_to_udp_meta_info.src_port);
        if (arb_to_udp_data_val && to_udp_arb_data_rdy)
            data_word_q.push_back(arb_to_udp_data[31:0]);
        if (prev_stall && (!arb_to_udp_data_val || (arb_to_udp_data !== prev_data))) hold_viol++;
        prev_stall = arb_to_udp_data_val && !to_udp_arb_data_rdy;
        prev_data  = arb_to_udp_data;
        @(posedge clk);
        #1;
        for (int s = 0; s < NS; s++) begin
            if (mh[s]) begin
                pkts_left[s]--;
                if ((pkt_len[s] + 63) / 64 == 0) begin
                    cur_pkt[s]++;
                end else begin
                    in_data[s]   = 1'b1;
                    beats_rem[s] = (pkt_len[s] + 63) / 64;
                    beat_no[s]   = 0;
                end
            end
            if (dh[s]) begin
                beat_no[s]++;
                beats_rem[s]--;
                if (beats_rem[s] <= 0) begin
                    in_data[s] = 1'b0;
                    cur_pkt[s]++;
                    beat_no[s] = 0;
                end
            end
        end
        if (toggle_rdy) to_udp_arb_data_rdy = ~to_udp_arb_data_rdy;
        drive_inputs();
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (arb_to_udp_meta_val !== 1'b0) begin errors++;
            $display("FAIL reset_meta_val: got %b want 0", arb_to_udp_meta_val); end
        checks++; if (arb_to_udp_data_val !== 1'b0) begin errors++;
            $display("FAIL reset_data_val: got %b want 0", arb_to_udp_data_val); end
        checks++; if (arb_src_meta_rdy !== 2'b00) begin errors++;
            $display("FAIL reset_meta_rdy: got %b want 00", arb_src_meta_rdy); end
        checks++; if (arb_src_data_rdy !== 2'b00) begin errors++;
            $display("FAIL reset_data_rdy: got %b want 00", arb_src_data_rdy); end
        checks++; if (arb_busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b want 0", arb_busy); end
        checks++; if (arb_grant_idx !== 1'b0) begin errors++;
            $display("FAIL reset_grant: got %0d want 0", arb_grant_idx); end
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        checks++; if (arb_busy !== 1'b0) begin errors++;
            $display("FAIL idle_after_reset_busy: got %b want 0", arb_busy); end
    endtask

    task automatic test_single();
        clear_logs();
        start_src(0, 1, 128, 1'b0);
        #1;
        checks++; if (arb_to_udp_meta_val !== 1'b0) begin errors++;
            $display("FAIL single_idle_no_val: got %b want 0", arb_to_udp_meta_val); end
        n = 0;
        while (n < 20 && data_src_q.size() < 2) begin tick(); n++; end
        checks++; if (n !== 4) begin errors++;
            $display("FAIL single_cycles: got %0d want 4", n); end
        checks++; if (arb_busy !== 1'b0) begin errors++;
            $display("FAIL single_busy_drop: got %b want 0", arb_busy); end
        checks++; if (meta_src_q.size() !== 1 || meta_src_q[0] !== 0) begin errors++;
            $display("FAIL single_meta: got size %0d src %0d want 1 src 0",
                     meta_src_q.size(), meta_src_q[0]); end
        checks++; if (data_word_q[0] !== tag(0, 0, 0) || data_word_q[1] !== tag(0, 0, 1)) begin
            errors++;
            $display("FAIL single_data: got %h %h want %h %h", data_word_q[0], data_word_q[1],
                     tag(0, 0, 0), tag(0, 0, 1)); end
    endtask

    task automatic test_alternate();
        int exp_meta [4];
        int exp_src  [6];
        logic [31:0] exp_word [6];
        exp_meta = '{1, 0, 1, 0};
        exp_src  = '{1, 0, 0, 1, 0, 0};
        exp_word = '{tag(1, 0, 0), tag(0, 0, 0), tag(0, 0, 1),
                     tag(1, 1, 0), tag(0, 1, 0), tag(0, 1, 1)};
        clear_logs();
        start_src(0, 2, 100, 1'b0);
        start_src(1, 2, 64, 1'b0);
        #1;
        n = 0;
        while (n < 60 && data_src_q.size() < 6) begin tick(); n++; end
        tick();
        checks++; if (meta_src_q.size() !== 4) begin errors++;
            $display("FAIL alt_meta_count: got %0d want 4", meta_src_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (meta_src_q[i] !== exp_meta[i]) begin errors++;
                $display("FAIL alt_grant_%0d: got %0d want %0d", i, meta_src_q[i], exp_meta[i]); end
        end
        for (int i = 0; i < 6; i++) begin
            checks++; if (data_src_q[i] !== exp_src[i] || data_word_q[i] !== exp_word[i]) begin
                errors++;
                $display("FAIL alt_beat_%0d: got src %0d word %h want src %0d word %h", i,
                         data_src_q[i], data_word_q[i], exp_src[i], exp_word[i]); end
        end
        checks++; if (meta_port_q[0] !== 16'h101 || meta_port_q[1] !== 16'h100) begin errors++;
            $display("FAIL alt_meta_info: got %h %h want 0101 0100", meta_port_q[0],
                     meta_port_q[1]); end
        checks++; if (arb_busy !== 1'b0) begin errors++;
            $display("FAIL alt_idle: got %b want 0", arb_busy); end
    endtask

    task automatic test_zero_len();
        clear_logs();
        start_src(1, 1, 0, 1'b0);
        #1;
        tick();
        checks++; if (arb_busy !== 1'b1 || arb_to_udp_meta_val !== 1'b1 || arb_grant_idx !== 1'b1)
        begin errors++;
            $display("FAIL zero_meta_phase: got busy %b val %b grant %0d want 1 1 1", arb_busy,
                     arb_to_udp_meta_val, arb_grant_idx); end
        tick();
        checks++; if (arb_busy !== 1'b0) begin errors++;
            $display("FAIL zero_back_idle: got %b want 0", arb_busy); end
        tick();
        checks++; if (meta_src_q.size() !== 1 || data_src_q.size() !== 0) begin errors++;
            $display("FAIL zero_counts: got meta %0d data %0d want 1 0", meta_src_q.size(),
                     data_src_q.size()); end
    endtask

    task automatic test_stall();
        clear_logs();
        hold_viol = 0;
        start_src(0, 1, 200, 1'b0);
        toggle_rdy = 1'b1;
        #1;
        n = 0;
        while (n < 40 && data_src_q.size() < 4) begin tick(); n++; end
        toggle_rdy = 1'b0;
        to_udp_arb_data_rdy = 1'b1;
        repeat (3) tick();
        checks++; if (data_src_q.size() !== 4) begin errors++;
            $display("FAIL stall_beats: got %0d want 4", data_src_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (data_word_q[i] !== tag(0, 0, i)) begin errors++;
                $display("FAIL stall_word_%0d: got %h want %h", i, data_word_q[i], tag(0, 0, i)); end
        end
        checks++; if (hold_viol !== 0) begin errors++;
            $display("FAIL stall_hold: got %0d violations want 0", hold_viol); end
        checks++; if (arb_busy !== 1'b0) begin errors++;
            $display("FAIL stall_idle: got %b want 0", arb_busy); end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        start_src(0, 1, 320, 1'b0);
        #1;
        n = 0;
        while (n < 20 && data_src_q.size() < 2) begin tick(); n++; end
        rst_n = 1'b0;
        #1;
        checks++; if (arb_to_udp_data_val !== 1'b0 || arb_src_data_rdy !== 2'b00) begin errors++;
            $display("FAIL rstmid_data: got val %b rdy %b want 0 00", arb_to_udp_data_val,
                     arb_src_data_rdy); end
        checks++; if (arb_busy !== 1'b0 || arb_to_udp_meta_val !== 1'b0) begin errors++;
            $display("FAIL rstmid_busy: got busy %b meta %b want 0 0", arb_busy,
                     arb_to_udp_meta_val); end
        for (int s = 0; s < NS; s++) begin
            pkts_left[s] = 0;
            in_data[s]   = 1'b0;
            early[s]     = 1'b0;
        end
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
        start_src(0, 1, 64, 1'b0);
        start_src(1, 1, 64, 1'b0);
        #1;
        n = 0;
        while (n < 20 && data_src_q.size() < 2) begin tick(); n++; end
        checks++; if (meta_src_q.size() !== 2 || meta_src_q[0] !== 0 || meta_src_q[1] !== 1)
        begin errors++;
            $display("FAIL rstmid_fresh_grant: got %0d then %0d want 0 then 1", meta_src_q[0],
                     meta_src_q[1]); end
    endtask

    task automatic test_early_data();
        clear_logs();
        rdy_viol = 0;
        start_src(0, 1, 192, 1'b0);
        start_src(1, 1, 64, 1'b1);
        #1;
        checks++; if (arb_src_data_rdy[1] !== 1'b0) begin errors++;
            $display("FAIL early_idle_rdy1: got %b want 0", arb_src_data_rdy[1]); end
        repeat (3) tick();
        checks++; if (src_arb_data_val[1] !== 1'b1 || arb_src_data_rdy[1] !== 1'b0 ||
                      arb_src_data_rdy[0] !== 1'b1) begin errors++;
            $display("FAIL early_stalled: got val1 %b rdy %b want 1 01", src_arb_data_val[1],
                     arb_src_data_rdy); end
        n = 0;
        while (n < 30 && data_src_q.size() < 4) begin tick(); n++; end
        checks++; if (data_src_q.size() !== 4 || data_src_q[2] !== 0 || data_src_q[3] !== 1)
        begin errors++;
            $display("FAIL early_order: got size %0d last srcs %0d %0d want 4 0 1",
                     data_src_q.size(), data_src_q[2], data_src_q[3]); end
        checks++; if (data_word_q[3] !== tag(1, 0, 0)) begin errors++;
            $display("FAIL early_word: got %h want %h", data_word_q[3], tag(1, 0, 0)); end
        checks++; if (rdy_viol !== 0) begin errors++;
            $display("FAIL early_rdy_rules: got %0d violations want 0", rdy_viol); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rdy_viol = 0;
        hold_viol = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        toggle_rdy = 1'b0;
        to_udp_arb_meta_rdy = 1'b1;
        to_udp_arb_data_rdy = 1'b1;
        for (int s = 0; s < NS; s++) begin
            pkts_left[s] = 0; pkt_len[s] = 0; in_data[s] = 1'b0; early[s] = 1'b0;
            beats_rem[s] = 0; beat_no[s] = 0; cur_pkt[s] = 0;
        end
        drive_inputs();
        test_reset();
        test_single();
        test_alternate();
        test_zero_len();
        test_stall();
        test_reset_mid();
        test_early_data();
        checks++; if (rdy_viol !== 0 || hold_viol !== 0) begin errors++;
            $display("FAIL protocol_overall: got rdy %0d hold %0d want 0 0", rdy_viol,
                     hold_viol); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
